// File: rtl/mmc_seq_pkg.sv
// Shared definitions for the MMC sector sequencer.
//   - command encodings presented on oCMD_COMMAND
//   - sequencer state enum
//   - error code reported when the response watchdog fires
package mmc_seq_pkg;

  localparam logic [3:0] MMC_CMD_INIT  = 4'h0;
  localparam logic [3:0] MMC_CMD_CMD0  = 4'h1;
  localparam logic [3:0] MMC_CMD_CMD1  = 4'h2;
  localparam logic [3:0] MMC_CMD_CMD16 = 4'h3;
  localparam logic [3:0] MMC_CMD_CMD17 = 4'h4;
  localparam logic [3:0] MMC_CMD_CMD24 = 4'h5;

  localparam logic [4:0] MMC_ERR_TIMEOUT = 5'h1F;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_ISSUE,
    S_WAIT,
    S_READY,
    S_FAIL
  } seq_state_t;

  // Sector commands carry the host sector number and report to the host;
  // everything else belongs to the init chain.
  function automatic logic is_sector_cmd(input logic [3:0] cmd);
    return (cmd == MMC_CMD_CMD17) || (cmd == MMC_CMD_CMD24);
  endfunction

endpackage

// File: rtl/mmc_seq_timer.sv
// 32-bit down-counter shared by the power-up delay and the response watchdog.
//   iCLOCK    clock
//   inRESET   asynchronous reset, active-low; counter starts at RESET_VAL
//   load      reload the counter with load_val this cycle
//   load_val  reload value
//   expired   1 while the counter sits at zero
// Loading N-1 makes expired rise in the N-th cycle after the load.
module mmc_seq_timer #(
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] cnt;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cnt <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign expired = (cnt == 32'd0);

endmodule

// File: rtl/mmc_sector_sequencer.sv
// Upstream sequencer for the 512-byte MMC command layer.
// Runs the power-up init chain (INIT, CMD0, CMD1, CMD16), then converts host
// sector requests into CMD17 (read) / CMD24 (write), retrying failed commands.
// Optional feature: define MMC_SEQ_TIMEOUT_EN to enable a response watchdog in
// S_WAIT that reports a failure with code 5'h1F after TIMEOUT_CYCLES.
// Ports:
//   iCLOCK, inRESET            clock, asynchronous active-low reset
//   iHOST_REINIT               pulse: abort and restart the init chain
//   iHOST_REQ/RW/SECTOR        host sector request (accepted while oHOST_BUSY=0)
//   oHOST_BUSY/DONE/ERROR      host handshake; DONE/ERROR are 1-cycle pulses
//   oHOST_ERROR_CODE           code of the last failure, held
//   oINIT_DONE, oINIT_FAIL     init chain result levels
//   oCMD_REQ/COMMAND/ADDR      command request to the command layer
//   iCMD_BUSY/SUCCESS/ERROR/ERROR_CODE  command layer status
module mmc_sector_sequencer
  import mmc_seq_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES   = 50000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iHOST_REINIT,
  input  logic        iHOST_REQ,
  input  logic        iHOST_RW,
  input  logic [31:0] iHOST_SECTOR,
  output logic        oHOST_BUSY,
  output logic        oHOST_DONE,
  output logic        oHOST_ERROR,
  output logic [4:0]  oHOST_ERROR_CODE,
  output logic        oINIT_DONE,
  output logic        oINIT_FAIL,
  output logic        oCMD_REQ,
  output logic [3:0]  oCMD_COMMAND,
  output logic [31:0] oCMD_ADDR,
  input  logic        iCMD_BUSY,
  input  logic        iCMD_SUCCESS,
  input  logic        iCMD_ERROR,
  input  logic [4:0]  iCMD_ERROR_CODE
);

  localparam logic [31:0] PWR_LOAD  = (PWRUP_CYCLES > 0)   ? 32'(PWRUP_CYCLES - 1)   : 32'd0;
  localparam logic [31:0] WD_LOAD   = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);

  seq_state_t  state, state_n;
  logic [3:0]  step, step_n;
  logic [7:0]  retry, retry_n;
  logic [31:0] sector_q;
  logic        sector_load;

  logic        req_n, done_n, error_n, busy_n, init_done_n, init_fail_n;
  logic [3:0]  command_n;
  logic [31:0] addr_n;
  logic [4:0]  code_n;

  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_expired;
  logic        cmd_fail;
  logic [4:0]  fail_code;

  mmc_seq_timer #(.RESET_VAL(PWR_LOAD)) u_timer (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

`ifdef MMC_SEQ_TIMEOUT_EN
  // A real response in the expiry cycle takes precedence over the watchdog.
  logic wd_fire;
  assign wd_fire   = (state == S_WAIT) && tmr_expired && !iCMD_ERROR && !iCMD_SUCCESS;
  assign cmd_fail  = iCMD_ERROR | wd_fire;
  assign fail_code = iCMD_ERROR ? iCMD_ERROR_CODE : MMC_ERR_TIMEOUT;
`else
  assign cmd_fail  = iCMD_ERROR;
  assign fail_code = iCMD_ERROR_CODE;
`endif

  always_comb begin
    state_n     = state;
    step_n      = step;
    retry_n     = retry;
    req_n       = 1'b0;
    command_n   = oCMD_COMMAND;
    addr_n      = oCMD_ADDR;
    done_n      = 1'b0;
    error_n     = 1'b0;
    code_n      = oHOST_ERROR_CODE;
    init_done_n = oINIT_DONE;
    init_fail_n = oINIT_FAIL;
    tmr_load    = 1'b0;
    tmr_val     = WD_LOAD;
    sector_load = 1'b0;

    if (iHOST_REINIT) begin
      // In-flight layer responses are simply not sampled in S_PWRUP.
      state_n     = S_PWRUP;
      step_n      = MMC_CMD_INIT;
      retry_n     = 8'd0;
      init_done_n = 1'b0;
      init_fail_n = 1'b0;
      tmr_load    = 1'b1;
      tmr_val     = PWR_LOAD;
    end else begin
      unique case (state)
        S_PWRUP: begin
          if (tmr_expired) begin
            state_n = S_ISSUE;
            step_n  = MMC_CMD_INIT;
            retry_n = 8'd0;
          end
        end
        S_ISSUE: begin
          if (!iCMD_BUSY) begin
            req_n     = 1'b1;
            command_n = step;
            addr_n    = is_sector_cmd(step) ? sector_q : 32'd0;
            state_n   = S_WAIT;
            tmr_load  = 1'b1;
          end
        end
        S_WAIT: begin
          if (cmd_fail) begin
            if (retry < RETRY_LIM) begin
              retry_n = retry + 8'd1;
              state_n = S_ISSUE;
            end else begin
              retry_n = 8'd0;
              code_n  = fail_code;
              if (is_sector_cmd(step)) begin
                error_n = 1'b1;
                state_n = S_READY;
              end else begin
                init_fail_n = 1'b1;
                state_n     = S_FAIL;
              end
            end
          end else if (iCMD_SUCCESS) begin
            retry_n = 8'd0;
            if (is_sector_cmd(step)) begin
              done_n  = 1'b1;
              state_n = S_READY;
            end else if (step == MMC_CMD_CMD16) begin
              init_done_n = 1'b1;
              state_n     = S_READY;
            end else begin
              step_n  = step + 4'd1;
              state_n = S_ISSUE;
            end
          end
        end
        S_READY: begin
          if (iHOST_REQ) begin
            sector_load = 1'b1;
            step_n      = iHOST_RW ? MMC_CMD_CMD24 : MMC_CMD_CMD17;
            retry_n     = 8'd0;
            state_n     = S_ISSUE;
          end
        end
        S_FAIL: begin
        end
        default: state_n = S_PWRUP;
      endcase
    end

    busy_n = (state_n != S_READY);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state            <= S_PWRUP;
      step             <= MMC_CMD_INIT;
      retry            <= 8'd0;
      oHOST_BUSY       <= 1'b1;
      oHOST_DONE       <= 1'b0;
      oHOST_ERROR      <= 1'b0;
      oHOST_ERROR_CODE <= 5'd0;
      oINIT_DONE       <= 1'b0;
      oINIT_FAIL       <= 1'b0;
      oCMD_REQ         <= 1'b0;
      oCMD_COMMAND     <= 4'd0;
      oCMD_ADDR        <= 32'd0;
    end else begin
      state            <= state_n;
      step             <= step_n;
      retry            <= retry_n;
      oHOST_BUSY       <= busy_n;
      oHOST_DONE       <= done_n;
      oHOST_ERROR      <= error_n;
      oHOST_ERROR_CODE <= code_n;
      oINIT_DONE       <= init_done_n;
      oINIT_FAIL       <= init_fail_n;
      oCMD_REQ         <= req_n;
      oCMD_COMMAND     <= command_n;
      oCMD_ADDR        <= addr_n;
    end
  end

  // Host sector latch: pure data, only meaningful once a request is accepted.
  always_ff @(posedge iCLOCK) begin
    if (sector_load) begin
      sector_q <= iHOST_SECTOR;
    end
  end

endmodule

// File: tb/tb_mmc_sector_sequencer.sv
// Directed bench for mmc_sector_sequencer with a command-layer responder model
// and a scoreboard of expected command requests.
module tb_mmc_sector_sequencer;

  logic        clk = 1'b0;
  logic        inRESET = 1'b0;
  logic        iHOST_REINIT = 1'b0;
  logic        iHOST_REQ = 1'b0;
  logic        iHOST_RW = 1'b0;
  logic [31:0] iHOST_SECTOR = 32'd0;
  logic        oHOST_BUSY, oHOST_DONE, oHOST_ERROR;
  logic [4:0]  oHOST_ERROR_CODE;
  logic        oINIT_DONE, oINIT_FAIL;
  logic        oCMD_REQ;
  logic [3:0]  oCMD_COMMAND;
  logic [31:0] oCMD_ADDR;
  logic        iCMD_BUSY = 1'b0;
  logic        iCMD_SUCCESS, iCMD_ERROR;
  logic [4:0]  iCMD_ERROR_CODE;

  logic        a_succ = 1'b0, a_err = 1'b0, m_succ = 1'b0;
  logic [4:0]  a_code = 5'd0;
  assign iCMD_SUCCESS    = a_succ | m_succ;
  assign iCMD_ERROR      = a_err;
  assign iCMD_ERROR_CODE = a_code;

  always #5 clk = ~clk;

  mmc_sector_sequencer #(
    .PWRUP_CYCLES   (16),
    .RETRY_MAX      (3),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .iCLOCK           (clk),
    .inRESET          (inRESET),
    .iHOST_REINIT     (iHOST_REINIT),
    .iHOST_REQ        (iHOST_REQ),
    .iHOST_RW         (iHOST_RW),
    .iHOST_SECTOR     (iHOST_SECTOR),
    .oHOST_BUSY       (oHOST_BUSY),
    .oHOST_DONE       (oHOST_DONE),
    .oHOST_ERROR      (oHOST_ERROR),
    .oHOST_ERROR_CODE (oHOST_ERROR_CODE),
    .oINIT_DONE       (oINIT_DONE),
    .oINIT_FAIL       (oINIT_FAIL),
    .oCMD_REQ         (oCMD_REQ),
    .oCMD_COMMAND     (oCMD_COMMAND),
    .oCMD_ADDR        (oCMD_ADDR),
    .iCMD_BUSY        (iCMD_BUSY),
    .iCMD_SUCCESS     (iCMD_SUCCESS),
    .iCMD_ERROR       (iCMD_ERROR),
    .iCMD_ERROR_CODE  (iCMD_ERROR_CODE)
  );

  typedef struct packed {logic [3:0] cmd; logic [31:0] addr;} exp_t;
  typedef struct packed {logic is_err; logic [4:0] code;} resp_t;

  exp_t  exp_q[$];
  resp_t plan_q[$];

  int total = 0, bad = 0;
  int req_cnt = 0, done_cnt = 0, err_cnt = 0;
  int cyc = 0, last_req_cyc = 0, err_cyc = 0;
  logic auto_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command layer model: checks each request against the scoreboard and
  // answers two cycles later from the response plan (success when empty).
  initial begin : layer
    logic  prev_req;
    int    rcnt;
    resp_t cur;
    exp_t  e;
    prev_req = 1'b0;
    rcnt     = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      a_succ = 1'b0;
      a_err  = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          if (cur.is_err) begin
            a_err  = 1'b1;
            a_code = cur.code;
          end else begin
            a_succ = 1'b1;
          end
        end
      end
      if (oHOST_DONE) done_cnt++;
      if (oHOST_ERROR) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (oCMD_REQ) begin
        req_cnt++;
        last_req_cyc = cyc;
        chk("req_one_cycle", {31'd0, prev_req}, 32'd0);
        chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("req_cmd", {28'd0, oCMD_COMMAND}, {28'd0, e.cmd});
          chk("req_addr", oCMD_ADDR, e.addr);
        end
        if (auto_en) begin
          cur  = (plan_q.size() != 0) ? plan_q.pop_front() : '0;
          rcnt = 2;
        end
      end
      prev_req = oCMD_REQ;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic push_init();
    for (int i = 0; i < 4; i++) exp_q.push_back({4'(i), 32'd0});
  endtask

  task automatic host_req(input logic rw, input logic [31:0] sec);
    @(negedge clk);
    iHOST_REQ    = 1'b1;
    iHOST_RW     = rw;
    iHOST_SECTOR = sec;
    @(negedge clk);
    iHOST_REQ    = 1'b0;
  endtask

  task automatic pulse_reinit();
    @(negedge clk);
    iHOST_REINIT = 1'b1;
    @(negedge clk);
    iHOST_REINIT = 1'b0;
  endtask

  // sel: 0 done_cnt>base, 1 err_cnt>base, 2 init done, 3 init fail, 4 req_cnt>base
  task automatic wait_for(input string tag, input int sel, input int base, input int bound);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      #1;
      case (sel)
        0: hit = (done_cnt > base);
        1: hit = (err_cnt > base);
        2: hit = oINIT_DONE;
        3: hit = oINIT_FAIL;
        default: hit = (req_cnt > base);
      endcase
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin : stim
    int rb, db, eb;

    // 1: reset values, then the init chain
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, oHOST_BUSY}, 32'd1);
    chk("rst_req", {31'd0, oCMD_REQ}, 32'd0);
    chk("rst_done", {31'd0, oHOST_DONE}, 32'd0);
    chk("rst_error", {31'd0, oHOST_ERROR}, 32'd0);
    chk("rst_code", {27'd0, oHOST_ERROR_CODE}, 32'd0);
    chk("rst_init_done", {31'd0, oINIT_DONE}, 32'd0);
    chk("rst_init_fail", {31'd0, oINIT_FAIL}, 32'd0);
    push_init();
    inRESET = 1'b1;
    wait_for("init_done_seen", 2, 0, 200);
    chk("init_req_count", req_cnt, 4);
    chk("init_busy", {31'd0, oHOST_BUSY}, 32'd0);
    chk("init_queue_empty", exp_q.size(), 0);

    // 2: CMD17 held off by iCMD_BUSY, then completes
    rb = req_cnt; db = done_cnt; eb = err_cnt;
    iCMD_BUSY = 1'b1;
    exp_q.push_back({4'h4, 32'h0000_0123});
    host_req(1'b0, 32'h0000_0123);
    repeat (5) @(negedge clk);
    chk("busy_no_req", req_cnt - rb, 0);
    chk("busy_host_busy", {31'd0, oHOST_BUSY}, 32'd1);
    iCMD_BUSY = 1'b0;
    wait_for("rd_done_seen", 0, db, 20);
    repeat (3) @(negedge clk);
    chk("rd_done_once", done_cnt - db, 1);
    chk("rd_no_error", err_cnt - eb, 0);
    chk("rd_req_count", req_cnt - rb, 1);
    chk("rd_ready", {31'd0, oHOST_BUSY}, 32'd0);

    // 2b: request-to-command latency of two cycles
    db = done_cnt;
    exp_q.push_back({4'h4, 32'h0000_0077});
    @(negedge clk);
    iHOST_REQ    = 1'b1;
    iHOST_RW     = 1'b0;
    iHOST_SECTOR = 32'h0000_0077;
    @(negedge clk);
    chk("lat_cycle1", {31'd0, oCMD_REQ}, 32'd0);
    iHOST_REQ = 1'b0;
    @(negedge clk);
    chk("lat_cycle2", {31'd0, oCMD_REQ}, 32'd1);
    wait_for("lat_done_seen", 0, db, 20);

    // 3: CMD24 fails twice with 5'h05, then succeeds
    rb = req_cnt; db = done_cnt; eb = err_cnt;
    plan_q.push_back({1'b1, 5'h05});
    plan_q.push_back({1'b1, 5'h05});
    for (int i = 0; i < 3; i++) exp_q.push_back({4'h5, 32'hABCD_0001});
    host_req(1'b1, 32'hABCD_0001);
    wait_for("wr_done_seen", 0, db, 60);
    repeat (3) @(negedge clk);
    chk("wr_req_count", req_cnt - rb, 3);
    chk("wr_done_once", done_cnt - db, 1);
    chk("wr_no_error", err_cnt - eb, 0);
    chk("wr_code_untouched", {27'd0, oHOST_ERROR_CODE}, 32'd0);

    // 4: CMD1 fails four times -> init failure
    plan_q.push_back({1'b0, 5'h00});
    plan_q.push_back({1'b0, 5'h00});
    for (int i = 0; i < 4; i++) plan_q.push_back({1'b1, 5'h05});
    exp_q.push_back({4'h0, 32'd0});
    exp_q.push_back({4'h1, 32'd0});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'h2, 32'd0});
    pulse_reinit();
    chk("reinit_clears_done", {31'd0, oINIT_DONE}, 32'd0);
    wait_for("init_fail_seen", 3, 0, 300);
    chk("fail_init_done", {31'd0, oINIT_DONE}, 32'd0);
    chk("fail_code", {27'd0, oHOST_ERROR_CODE}, 32'h05);
    chk("fail_busy", {31'd0, oHOST_BUSY}, 32'd1);
    chk("fail_queue_empty", exp_q.size(), 0);
    rb = req_cnt;
    host_req(1'b0, 32'h0000_0042);
    repeat (10) @(negedge clk);
    chk("fail_req_ignored", req_cnt - rb, 0);
    chk("fail_level_held", {31'd0, oINIT_FAIL}, 32'd1);
    push_init();
    pulse_reinit();
    chk("reinit_clears_fail", {31'd0, oINIT_FAIL}, 32'd0);
    wait_for("reinit_done_seen", 2, 0, 200);
    chk("reinit_queue_empty", exp_q.size(), 0);

    // 5: iHOST_REINIT together with iCMD_SUCCESS in S_WAIT
    rb = req_cnt; db = done_cnt;
    auto_en = 1'b0;
    exp_q.push_back({4'h4, 32'h0000_0055});
    host_req(1'b0, 32'h0000_0055);
    wait_for("abort_req_seen", 4, rb, 10);
    @(negedge clk);
    m_succ       = 1'b1;
    iHOST_REINIT = 1'b1;
    @(negedge clk);
    m_succ       = 1'b0;
    iHOST_REINIT = 1'b0;
    chk("abort_init_done", {31'd0, oINIT_DONE}, 32'd0);
    chk("abort_busy", {31'd0, oHOST_BUSY}, 32'd1);
    push_init();
    auto_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - db, 0);
    wait_for("abort_reinit_seen", 2, 0, 200);
    chk("abort_req_count", req_cnt - rb, 5);
    chk("abort_queue_empty", exp_q.size(), 0);

`ifdef MMC_SEQ_TIMEOUT_EN
    // 6: silent layer, watchdog failure after retries
    rb = req_cnt; db = done_cnt; eb = err_cnt;
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({4'h4, 32'h0000_0099});
    host_req(1'b0, 32'h0000_0099);
    wait_for("wd_error_seen", 1, eb, 1000);
    repeat (2) @(negedge clk);
    chk("wd_code", {27'd0, oHOST_ERROR_CODE}, 32'h1F);
    chk("wd_error_once", err_cnt - eb, 1);
    chk("wd_no_done", done_cnt - db, 0);
    chk("wd_req_count", req_cnt - rb, 4);
    chk("wd_latency", err_cyc - last_req_cyc, 100);
    auto_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
